// File: rtl/muxnway_rr_if.sv
// Bundle for the N-way selector: per-channel input handshake, select/mode controls,
// the registered output handshake, and the round-robin pointer for observation.
interface muxnway_rr_if #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic               rr_en;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    dbg_ptr;

  // Handshake: a word moves across a port on a rising edge when valid and ready are
  // both high. Valid never depends on ready; in_ready is combinational from
  // in_valid/sel/rr_en/out_ready and the block state.
  modport master (
    output in_data, in_valid, sel, rr_en, out_ready,
    input  in_ready, out_data, out_sel, out_valid, dbg_ptr
  );

  modport slave (
    input  in_data, in_valid, sel, rr_en, out_ready,
    output in_ready, out_data, out_sel, out_valid, dbg_ptr
  );
endinterface

// File: rtl/muxnway_rr.sv
// N-way WIDTH-bit selector feeding a one-entry output register; channel chosen by a
// fixed index or by round-robin starting after the last RR-granted channel.
module muxnway_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  muxnway_rr_if.slave   bus
);

  localparam logic [SELW:0]   N_CNT    = (SELW+1)'(N);
  localparam logic [SELW-1:0] PTR_INIT = SELW'(N - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             sel_in_range;
  logic [SELW:0]    cand;
  logic             rr_hit;
  logic [SELW-1:0]  rr_idx;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic [N-1:0]     in_ready_w;

  always_comb begin
    load_en      = !out_valid_q || bus.out_ready;
    sel_in_range = ({1'b0, bus.sel} < N_CNT);

    // Search ptr+1 .. ptr+N modulo N; the last step revisits ptr itself.
    cand   = '0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr_q} + (SELW+1)'(k);
      if (cand >= N_CNT) cand = cand - N_CNT;
      if (!rr_hit && bus.in_valid[cand[SELW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = cand[SELW-1:0];
      end
    end

    if (bus.rr_en) begin
      grant_vld = rr_hit;
      grant_idx = rr_idx;
    end else begin
      grant_vld = sel_in_range && bus.in_valid[bus.sel];
      grant_idx = bus.sel;
    end

    // Reset masks the grant so nothing is consumed from a channel during reset.
    xfer = load_en && grant_vld && !reset;

    in_ready_w = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        in_ready_w[i] = xfer;
        grant_data    = bus.in_data[i*WIDTH +: WIDTH];
      end
    end

    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      if (bus.rr_en) ptr_d = grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= PTR_INIT;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dbg_ptr   = ptr_q;

endmodule
